demux_lanes: RTL and testbench
==============================

Name: demux_lanes

Overview:
- Receive-side counterpart of the 2:1 lane mux.
- Takes one time-interleaved byte stream running on the fast (2f) clock and splits it back into two parallel lanes, lane 0 and lane 1.
- Both lanes update together once per slot pair and hold their values for two cycles, which yields the half-rate lane timing.
- Aligns to the first valid word after reset and re-aligns after a sustained idle gap.

Parameters:
- WIDTH, 8, bit width of each data word.
- IDLE_PAIRS, 4, number of consecutive fully-empty slot pairs in ACTIVE that force a return to IDLE (resync). Legal range 1..255.

Ports:
- clk  input  1  fast (2f) clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  interleaved data word; lane 0 slot, then lane 1 slot, alternating.
- valid_in  input  1  data_in qualifier for the current slot.
- data_out_0  output  WIDTH  lane 0 data, registered.
- valid_out_0  output  1  lane 0 valid, registered.
- data_out_1  output  WIDTH  lane 1 data, registered.
- valid_out_1  output  1  lane 1 valid, registered.
- active  output  1  high while the FSM is in ACTIVE, registered.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation). All of the following go to 0:
  - outputs: data_out_0/1, valid_out_0/1, active;
  - internal state: hold_d0, hold_v0, sel, idle counter;
  - FSM goes to IDLE.
- Internal state:
  - sel: slot selector; 0 = lane 0 slot, 1 = lane 1 slot.
  - hold_d0/hold_v0: lane 0 holding register.
  - idle_cnt: count of consecutive empty pairs, 8 bits.
- FSM IDLE:
  - sel held at 0.
  - Edge with valid_in=0: no state change.
  - Edge with valid_in=1: hold_d0<=data_in, hold_v0<=1, sel<=1, idle_cnt<=0, go to ACTIVE, active<=1.
  - The first valid word after reset or resync is always lane 0.
- FSM ACTIVE: sel toggles on every edge, regardless of valid_in.
  - Edge with sel=0 (lane 0 slot): hold_d0<=data_in, hold_v0<=valid_in. Outputs unchanged.
  - Edge with sel=1 (pair-completion edge):
    - valid_out_0<=hold_v0; data_out_0<=hold_d0 if hold_v0, else data_out_0 keeps its value.
    - valid_out_1<=valid_in; data_out_1<=data_in if valid_in, else data_out_1 keeps its value.
    - Both lanes update on the same edge, then stay stable for 2 cycles.
- Latency:
  - Lane 0 word sampled at edge k appears after edge k+1.
  - Lane 1 word sampled at edge k+1 appears after edge k+1.
  - Sustained throughput: one word per lane every 2 clk cycles.
- Idle detection, evaluated at each pair-completion edge:
  - If hold_v0=0 and valid_in=0: the pair is empty and idle_cnt increments; otherwise idle_cnt<=0.
  - If the pair is empty and idle_cnt==IDLE_PAIRS-1: go to IDLE, active<=0, sel<=0, idle_cnt<=0.
  - The empty pair is still published on that edge (valid_out_0/1 = 0).
- Partial pairs (one lane valid, the other not):
  - Published with per-lane valid.
  - Count as non-empty; reset idle_cnt.
- In IDLE, data_out_x and valid_out_x keep their last published values. After a resync these are valid=0.
- A valid_in=1 arriving on the same edge that returns the FSM to IDLE is impossible, because that edge's pair is empty by definition.
- idle_cnt never exceeds IDLE_PAIRS-1; there is no wrap.

Test Plan:
- Reset then stream: assert reset, release, drive valid_in=1 with data 0x11, 0x22, 0x33, 0x44 on consecutive edges -> after edge 2: data_out_0=0x11, data_out_1=0x22, both valids 1, active=1. After edge 4: 0x33/0x44. Outputs stable between.
- Leading idle: valid_in=0 for 5 cycles after reset, then 0xA5, 0x5A -> active stays 0 until the 0xA5 edge. Lane 0 shows 0xA5, lane 1 shows 0x5A, regardless of odd idle length.
- Partial pair: pair (0x10 valid, 0x20 invalid) -> valid_out_0=1, data_out_0=0x10, valid_out_1=0, data_out_1 keeps its previous value. idle_cnt stays 0.
- Resync: in ACTIVE, drive 4 fully invalid pairs (8 cycles) -> active falls on the 8th edge with both valids 0. Next valid word 0x77 lands on lane 0, with sel re-aligned even when the gap ends on an odd cycle.
- Short gap: 3 empty pairs then a valid pair -> active remains 1 throughout; idle_cnt clears.
- Reset mid-pair: assert reset asynchronously between the lane 0 and lane 1 slots, with lane 0 holding 0xC3 -> all outputs 0 immediately. 0xC3 is never published. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/demux_lanes_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_lanes_if
// Description : Bus bundle for the lane demultiplexer. Carries the
//               interleaved input stream and the two de-interleaved lanes.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_lanes_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_out_0;
    logic             valid_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic             valid_out_1;
    logic             active;

    // Stream source / lane consumer side
    modport master (
        output data_in,
        output valid_in,
        input  data_out_0,
        input  valid_out_0,
        input  data_out_1,
        input  valid_out_1,
        input  active
    );

    // Demultiplexer side
    modport slave (
        input  data_in,
        input  valid_in,
        output data_out_0,
        output valid_out_0,
        output data_out_1,
        output valid_out_1,
        output active
    );
endinterface : demux_lanes_if
`default_nettype wire

// File: rtl/demux_lanes.sv
`default_nettype none
// ============================================================================
// Module      : demux_lanes
// Description : Splits a time-interleaved word stream on the fast clock into
//               two parallel lanes that update together once per slot pair.
//               Aligns lane 0 to the first valid word and re-aligns after a
//               run of IDLE_PAIRS fully-empty pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lanes #(
    parameter int WIDTH      = 8,
    parameter int IDLE_PAIRS = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    demux_lanes_if.slave   bus
);

    // Counter value on which one more empty pair forces a resync
    localparam logic [7:0] c_IDLE_LAST = 8'(IDLE_PAIRS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_hold_d0;
    logic             r_hold_v0;
    logic             r_sel;
    logic [7:0]       r_idle_cnt;
    logic [WIDTH-1:0] r_data_out_0;
    logic             r_valid_out_0;
    logic [WIDTH-1:0] r_data_out_1;
    logic             r_valid_out_1;
    logic             r_active;

    logic [WIDTH-1:0] w_hold_d0_nxt;
    logic             w_hold_v0_nxt;
    logic             w_sel_nxt;
    logic [7:0]       w_idle_cnt_nxt;
    logic [WIDTH-1:0] w_data_out_0_nxt;
    logic             w_valid_out_0_nxt;
    logic [WIDTH-1:0] w_data_out_1_nxt;
    logic             w_valid_out_1_nxt;
    logic             w_active_nxt;
    logic             w_pair_empty;

    // A pair is empty when neither the held lane 0 word nor the current
    // lane 1 word is valid; only meaningful on the pair-completion edge.
    assign w_pair_empty = ~r_hold_v0 & ~bus.valid_in;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the FSM and lane datapath
    always_comb begin
        w_state_nxt       = r_state;
        w_hold_d0_nxt     = r_hold_d0;
        w_hold_v0_nxt     = r_hold_v0;
        w_sel_nxt         = r_sel;
        w_idle_cnt_nxt    = r_idle_cnt;
        w_data_out_0_nxt  = r_data_out_0;
        w_valid_out_0_nxt = r_valid_out_0;
        w_data_out_1_nxt  = r_data_out_1;
        w_valid_out_1_nxt = r_valid_out_1;
        w_active_nxt      = r_active;

        case (r_state)
            S_IDLE: begin
                // First valid word after reset/resync is always lane 0
                w_sel_nxt = 1'b0;
                if (bus.valid_in) begin
                    w_hold_d0_nxt  = bus.data_in;
                    w_hold_v0_nxt  = 1'b1;
                    w_sel_nxt      = 1'b1;
                    w_idle_cnt_nxt = 8'd0;
                    w_state_nxt    = S_ACTIVE;
                    w_active_nxt   = 1'b1;
                end
            end

            S_ACTIVE: begin
                w_sel_nxt = ~r_sel;
                if (!r_sel) begin
                    // Lane 0 slot: capture into the holding register
                    w_hold_d0_nxt = bus.data_in;
                    w_hold_v0_nxt = bus.valid_in;
                end else begin
                    // Pair completion: publish both lanes together; data
                    // is only replaced where its lane is valid.
                    w_valid_out_0_nxt = r_hold_v0;
                    if (r_hold_v0) begin
                        w_data_out_0_nxt = r_hold_d0;
                    end
                    w_valid_out_1_nxt = bus.valid_in;
                    if (bus.valid_in) begin
                        w_data_out_1_nxt = bus.data_in;
                    end

                    if (w_pair_empty) begin
                        if (r_idle_cnt == c_IDLE_LAST) begin
                            w_state_nxt    = S_IDLE;
                            w_active_nxt   = 1'b0;
                            w_sel_nxt      = 1'b0;
                            w_idle_cnt_nxt = 8'd0;
                        end else begin
                            w_idle_cnt_nxt = r_idle_cnt + 8'd1;
                        end
                    end else begin
                        w_idle_cnt_nxt = 8'd0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_d0     <= '0;
            r_hold_v0     <= 1'b0;
            r_sel         <= 1'b0;
            r_idle_cnt    <= 8'd0;
            r_data_out_0  <= '0;
            r_valid_out_0 <= 1'b0;
            r_data_out_1  <= '0;
            r_valid_out_1 <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_hold_d0     <= w_hold_d0_nxt;
            r_hold_v0     <= w_hold_v0_nxt;
            r_sel         <= w_sel_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_data_out_0  <= w_data_out_0_nxt;
            r_valid_out_0 <= w_valid_out_0_nxt;
            r_data_out_1  <= w_data_out_1_nxt;
            r_valid_out_1 <= w_valid_out_1_nxt;
            r_active      <= w_active_nxt;
        end
    end

    assign bus.data_out_0  = r_data_out_0;
    assign bus.valid_out_0 = r_valid_out_0;
    assign bus.data_out_1  = r_data_out_1;
    assign bus.valid_out_1 = r_valid_out_1;
    assign bus.active      = r_active;

endmodule : demux_lanes
`default_nettype wire

// File: tb/tb_demux_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_lanes
// Description : Directed self-checking bench for demux_lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_lanes;

    localparam int c_WIDTH      = 8;
    localparam int c_IDLE_PAIRS = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    demux_lanes_if #(.WIDTH(c_WIDTH)) bus ();

    demux_lanes #(
        .WIDTH      (c_WIDTH),
        .IDLE_PAIRS (c_IDLE_PAIRS)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d0, input logic v0,
                           input logic [7:0] d1, input logic v1, input logic act);
        chk_val({tag, ".d0"},  32'(bus.data_out_0),  32'(d0));
        chk_val({tag, ".v0"},  32'(bus.valid_out_0), 32'(v0));
        chk_val({tag, ".d1"},  32'(bus.data_out_1),  32'(d1));
        chk_val({tag, ".v1"},  32'(bus.valid_out_1), 32'(v1));
        chk_val({tag, ".act"}, 32'(bus.active),      32'(act));
    endtask

    // Drive one slot, clock it in, and settle 1 time unit past the edge
    task automatic step(input logic [7:0] d, input logic v);
        bus.data_in  = d;
        bus.valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        #3;
        chk_out("rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();

        // ---- Reset then stream ----
        step(8'h11, 1'b1);
        chk_out("s1", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(8'h22, 1'b1);
        chk_out("s2", 8'h11, 1'b1, 8'h22, 1'b1, 1'b1);
        step(8'h33, 1'b1);
        chk_out("s3", 8'h11, 1'b1, 8'h22, 1'b1, 1'b1);
        step(8'h44, 1'b1);
        chk_out("s4", 8'h33, 1'b1, 8'h44, 1'b1, 1'b1);

        // ---- Partial pair: lane 1 keeps old data ----
        step(8'h10, 1'b1);
        step(8'h20, 1'b0);
        chk_out("part", 8'h10, 1'b1, 8'h44, 1'b0, 1'b1);

        // ---- Short gap: 3 empty pairs, then a valid pair ----
        for (int i = 0; i < 3; i++) begin
            step(8'hEE, 1'b0);
            step(8'hEE, 1'b0);
            chk_out("gapA", 8'h10, 1'b0, 8'h44, 1'b0, 1'b1);
        end
        step(8'h55, 1'b1);
        step(8'h66, 1'b1);
        chk_out("gapA.end", 8'h55, 1'b1, 8'h66, 1'b1, 1'b1);
        // Counter must have cleared: another 3 empty pairs stay active
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0);
            step(8'h00, 1'b0);
            chk_out("gapB", 8'h55, 1'b0, 8'h66, 1'b0, 1'b1);
        end
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        chk_out("gapB.end", 8'h01, 1'b1, 8'h02, 1'b1, 1'b1);

        // ---- Resync: 4 empty pairs ----
        for (int i = 0; i < 7; i++) step(8'h00, 1'b0);
        chk_out("rs7", 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
        step(8'h00, 1'b0);
        chk_out("rs8", 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        // Odd-length tail of idle in IDLE
        for (int i = 0; i < 3; i++) step(8'h99, 1'b0);
        chk_out("rs.idle", 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        step(8'h77, 1'b1);
        chk_out("rs.77", 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
        step(8'h88, 1'b1);
        chk_out("rs.88", 8'h77, 1'b1, 8'h88, 1'b1, 1'b1);

        // ---- Leading idle after reset (odd length) ----
        do_reset();
        chk_out("li.rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(8'h3C, 1'b0);
            chk_out("li.idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        step(8'hA5, 1'b1);
        chk_out("li.a5", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(8'h5A, 1'b1);
        chk_out("li.5a", 8'hA5, 1'b1, 8'h5A, 1'b1, 1'b1);

        // ---- Reset mid-pair with 0xC3 held in lane 0 ----
        step(8'hC3, 1'b1);
        chk_out("mp.hold", 8'hA5, 1'b1, 8'h5A, 1'b1, 1'b1);
        #2;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        chk_out("mp.async", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(8'hC3, 1'b0);
        chk_out("mp.idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'hD4, 1'b1);
        chk_out("mp.d4", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(8'hE5, 1'b1);
        chk_out("mp.e5", 8'hD4, 1'b1, 8'hE5, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux_lanes
`default_nettype wire
